ps2_rx_fifo: RTL and testbench

Parametrised PS/2 device-to-host receiver. It runs entirely in the system clock domain and oversamples the raw PS/2 clock and data lines. Each line passes through a two-flop synchroniser, and the clock line also passes through a glitch filter. The block decodes start, data, parity and stop bits, checks parity and framing, aborts stalled frames on a timeout, and buffers good bytes in a first-word-fall-through FIFO for the keyboard/controller logic that reads them.

---
 rtl/ps2_rx_fifo.sv | 247 ++++++++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: sync, clock glitch filter, frame decoder
// with parity/framing/timeout checks, and a first-word-fall-through FIFO.
module ps2_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 1000,
    parameter bit ODD_PARITY = 1'b1
) (
    input  logic                          CLK,
    input  logic                          Resetn,
    input  logic                          PS2CLK,
    input  logic                          PS2DATA,
    input  logic                          ReadEn,
    input  logic                          ClearErr,
    output logic [DATA_BITS-1:0]          ReadVal,
    output logic                          Interrupt,
    output logic [$clog2(FIFO_DEPTH):0]   Count,
    output logic                          ParityErr,
    output logic                          FrameErr,
    output logic                          Overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [FW-1:0] FLAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
    localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);
    localparam logic [CW-1:0] CFULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_e;

    logic clk_s1_q, clk_s2_q;
    logic dat_s1_q, dat_s2_q;

    always_ff @(posedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= PS2CLK;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= PS2DATA;
            dat_s2_q <= dat_s1_q;
        end
    end

    // fclk only follows the synced clock after FILTER_LEN agreeing samples
    logic          fclk_q, fclk_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          fclk_prev_q;
    logic          strobe_q;

    always_comb begin
        fclk_d = fclk_q;
        fcnt_d = '0;
        if (clk_s2_q != fclk_q) begin
            if (fcnt_q == FLAST) begin
                fclk_d = ~fclk_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            fclk_q      <= 1'b1;
            fcnt_q      <= '0;
            fclk_prev_q <= 1'b1;
            strobe_q    <= 1'b0;
        end else begin
            fclk_q      <= fclk_d;
            fcnt_q      <= fcnt_d;
            fclk_prev_q <= fclk_q;
            strobe_q    <= fclk_prev_q & ~fclk_q;
        end
    end

    state_e                 state_q, state_d;
    logic [BW-1:0]          bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic [TW-1:0]          tcnt_q, tcnt_d;
    logic                   push;
    logic                   perr_set;
    logic                   ferr_set;
    logic                   par_ok;

    assign par_ok = ((^shift_q) ^ par_q) == ODD_PARITY;

    always_comb begin
        state_d  = state_q;
        bcnt_d   = bcnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        tcnt_d   = '0;
        push     = 1'b0;
        perr_set = 1'b0;
        ferr_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (strobe_q && !dat_s2_q) begin
                    state_d = DATA;
                    bcnt_d  = '0;
                end
            end
            DATA: begin
                if (strobe_q) begin
                    shift_d = shift_q >> 1;
                    shift_d[DATA_BITS-1] = dat_s2_q;
                    if (bcnt_q == BLAST) begin
                        state_d = PARITY;
                    end else begin
                        bcnt_d = bcnt_q + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (strobe_q) begin
                    par_d   = dat_s2_q;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (strobe_q) begin
                    state_d  = IDLE;
                    perr_set = ~par_ok;
                    ferr_set = ~dat_s2_q;
                    push     = dat_s2_q & par_ok;
                end
            end
            default: state_d = IDLE;
        endcase
        // a stalled frame is dropped once the inter-strobe gap hits TIMEOUT
        if (state_q != IDLE && !strobe_q) begin
            if (tcnt_q == TLAST) begin
                state_d  = IDLE;
                ferr_set = 1'b1;
            end else begin
                tcnt_d = tcnt_q + TW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tcnt_q  <= tcnt_d;
        end
    end

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wptr_q, wptr_d;
    logic [PW-1:0]        rptr_q, rptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 empty, full, pop, wr, ovf_set;

    assign empty   = count_q == '0;
    assign full    = count_q == CFULL;
    assign pop     = ReadEn & ~empty;
    // a full FIFO still accepts a byte when the head leaves in the same cycle
    assign wr      = push & (~full | pop);
    assign ovf_set = push & full & ~pop;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q + CW'(wr) - CW'(pop);
        if (wr) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PW'(1);
        end
    end

    always_ff @(posedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr) begin
            mem_q[wptr_q] <= shift_q;
        end
    end

    logic perr_q, perr_d;
    logic ferr_q, ferr_d;
    logic ovf_q, ovf_d;

    assign perr_d = (perr_q & ~ClearErr) | perr_set;
    assign ferr_d = (ferr_q & ~ClearErr) | ferr_set;
    assign ovf_d  = (ovf_q & ~ClearErr) | ovf_set;

    always_ff @(posedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            perr_q <= perr_d;
            ferr_q <= ferr_d;
            ovf_q  <= ovf_d;
        end
    end

    assign ReadVal   = empty ? '0 : mem_q[rptr_q];
    assign Interrupt = ~empty;
    assign Count     = count_q;
    assign ParityErr = perr_q;
    assign FrameErr  = ferr_q;
    assign Overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: PS/2 frames in, queue model of the
// expected byte stream and sticky flags, monitor pops and compares.
module tb_ps2_rx_fifo;

    localparam int DB    = 8;
    localparam int DEPTH = 4;
    localparam int FL    = 4;
    localparam int TO    = 200;
    localparam int H     = 20;
    localparam bit ODD   = 1'b1;

    logic       CLK = 1'b0;
    logic       Resetn;
    logic       PS2CLK;
    logic       PS2DATA;
    logic       ReadEn;
    logic       ClearErr;
    logic [7:0] ReadVal;
    logic       Interrupt;
    logic [2:0] Count;
    logic       ParityErr;
    logic       FrameErr;
    logic       Overflow;

    always #5 CLK = ~CLK;

    ps2_rx_fifo #(
        .DATA_BITS (DB),
        .FIFO_DEPTH(DEPTH),
        .FILTER_LEN(FL),
        .TIMEOUT   (TO),
        .ODD_PARITY(ODD)
    ) dut (
        .CLK      (CLK),
        .Resetn   (Resetn),
        .PS2CLK   (PS2CLK),
        .PS2DATA  (PS2DATA),
        .ReadEn   (ReadEn),
        .ClearErr (ClearErr),
        .ReadVal  (ReadVal),
        .Interrupt(Interrupt),
        .Count    (Count),
        .ParityErr(ParityErr),
        .FrameErr (FrameErr),
        .Overflow (Overflow)
    );

    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    bit         e_perr = 0;
    bit         e_ferr = 0;
    bit         e_ovf = 0;
    bit         rd_on = 0;
    bit         force_pop = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_ParityErr"}, ParityErr, e_perr);
        chk({tag, "_FrameErr"}, FrameErr, e_ferr);
        chk({tag, "_Overflow"}, Overflow, e_ovf);
    endtask

    // Monitor: owns ReadEn and checks every byte leaving the FIFO
    initial begin
        ReadEn = 1'b0;
        forever begin
            @(posedge CLK);
            #2;
            ReadEn = rd_on ? 1'($urandom_range(0, 1)) : force_pop;
            @(negedge CLK);
            if (ReadEn && Interrupt) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_pop: got %0h, expected none",
                             ReadVal);
                end else begin
                    chk("pop_readval", ReadVal, exp_q.pop_front());
                end
            end
        end
    end

    // Reference: odd/even count of ones decides parity, then queue semantics
    task automatic model_frame(input logic [7:0] d, input bit pb,
                               input bit stop, input bit pop_planned);
        bit good;
        good = (($countones(d) + pb) % 2) == (ODD ? 1 : 0);
        if (!good) e_perr = 1;
        if (!stop) e_ferr = 1;
        if (good && stop) begin
            if (exp_q.size() < DEPTH || pop_planned) exp_q.push_back(d);
            else e_ovf = 1;
        end
    endtask

    task automatic send_bit(input bit b, input bit pop);
        PS2DATA = b;
        wait_cyc(H);
        PS2CLK = 1'b0;
        if (pop) begin
            wait_cyc(FL + 3);
            force_pop = 1;
            wait_cyc(1);
            force_pop = 0;
            wait_cyc(H - FL - 4);
        end else begin
            wait_cyc(H);
        end
        PS2CLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit flip,
                              input bit stop, input bit pop);
        bit pb;
        pb = ODD ? ($countones(d) % 2 == 0) : ($countones(d) % 2 == 1);
        pb ^= flip;
        model_frame(d, pb, stop, pop);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0);
        send_bit(pb, 1'b0);
        send_bit(stop, pop);
        PS2DATA = 1'b1;
        wait_cyc(H);
    endtask

    task automatic pop_one();
        force_pop = 1;
        wait_cyc(1);
        force_pop = 0;
        wait_cyc(1);
    endtask

    task automatic clear_err();
        ClearErr = 1'b1;
        wait_cyc(1);
        ClearErr = 1'b0;
        e_perr = 0;
        e_ferr = 0;
        e_ovf  = 0;
        wait_cyc(1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        rd_on = 1;
        while (exp_q.size() != 0 && t < 500) begin
            wait_cyc(1);
            t++;
        end
        chk("drain_left", exp_q.size(), 0);
        wait_cyc(2);
        rd_on = 0;
        wait_cyc(2);
        chk("drain_irq", Interrupt, 0);
        chk("drain_count", Count, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        Resetn   = 1'b0;
        PS2CLK   = 1'b1;
        PS2DATA  = 1'b1;
        ClearErr = 1'b0;
        wait_cyc(3);
        chk("rst_readval", ReadVal, 0);
        chk("rst_irq", Interrupt, 0);
        chk("rst_count", Count, 0);
        chk_flags("rst");
        Resetn = 1'b1;
        wait_cyc(2);

        send_frame(8'h1C, 0, 1, 0);
        chk("basic_readval", ReadVal, 8'h1C);
        chk("basic_irq", Interrupt, 1);
        chk("basic_count", Count, exp_q.size());
        chk_flags("basic");
        pop_one();
        chk("basic_pop_irq", Interrupt, 0);
        chk("basic_pop_readval", ReadVal, 0);

        send_frame(8'h1C, 1, 1, 0);
        chk_flags("badpar");
        chk("badpar_count", Count, 0);
        clear_err();
        chk_flags("badpar_clr");
        send_frame(8'hF0, 0, 1, 0);
        chk("f0_readval", ReadVal, 8'hF0);
        pop_one();

        PS2DATA = 1'b0;
        wait_cyc(H);
        for (int g = 0; g < 3; g++) begin
            PS2CLK = 1'b0;
            wait_cyc(3);
            PS2CLK = 1'b1;
            wait_cyc(10);
        end
        PS2DATA = 1'b1;
        wait_cyc(TO + 50);
        chk_flags("glitch3");
        chk("glitch3_count", Count, 0);
        PS2DATA = 1'b0;
        wait_cyc(5);
        PS2CLK = 1'b0;
        wait_cyc(4);
        PS2CLK = 1'b1;
        wait_cyc(10);
        PS2DATA = 1'b1;
        wait_cyc(TO + 50);
        e_ferr = 1;
        chk_flags("glitch4");
        clear_err();

        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        wait_cyc(TO + 50);
        e_ferr = 1;
        chk_flags("timeout");
        chk("timeout_count", Count, 0);
        clear_err();
        send_frame(8'h5A, 0, 1, 0);
        chk("5a_readval", ReadVal, 8'h5A);
        chk_flags("5a");
        pop_one();

        send_frame(8'($urandom), 0, 0, 0);
        chk_flags("stop0");
        chk("stop0_count", Count, 0);
        clear_err();

        for (int i = 1; i <= 5; i++) send_frame(8'(i), 0, 1, 0);
        chk("ovf_count", Count, 4);
        chk_flags("ovf");
        chk("ovf_head", ReadVal, 8'h01);
        send_frame(8'h06, 0, 1, 1);
        chk("full_pushpop_count", Count, 4);
        chk("full_model_size", exp_q.size(), 4);
        chk("full_pushpop_head", ReadVal, 8'h02);
        drain();
        clear_err();

        send_frame(8'h11, 0, 1, 0);
        send_frame(8'h22, 0, 1, 0);
        chk("rstmid_count2", Count, 2);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        Resetn = 1'b0;
        exp_q.delete();
        e_perr = 0;
        e_ferr = 0;
        e_ovf  = 0;
        #1;
        chk("rstmid_count", Count, 0);
        chk("rstmid_irq", Interrupt, 0);
        chk("rstmid_readval", ReadVal, 0);
        chk_flags("rstmid");
        wait_cyc(3);
        Resetn = 1'b1;
        wait_cyc(2);
        send_frame(8'h29, 0, 1, 0);
        chk("after_rst_count", Count, 1);
        chk("after_rst_readval", ReadVal, 8'h29);
        chk_flags("after_rst");
        pop_one();

        rd_on = 1;
        for (int n = 0; n < 20; n++) begin
            d = 8'($urandom);
            send_frame(d, $urandom_range(0, 4) == 0,
                       $urandom_range(0, 5) != 0, 0);
            chk_flags("rand");
            wait_cyc($urandom_range(0, 15));
        end
        drain();
        chk_flags("rand_end");
        clear_err();
        chk_flags("final_clr");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
